// File: rtl/gcbp_read_sched.sv
// Read-side scheduler for the GCBP BRAM array: walks 16 sub-images, issuing 64 current-frame
// then 64 previous-frame line reads each, and tags the data returning one cycle later.
module gcbp_read_sched #(
  parameter int C_SUBIMAGE_HEIGHT = 64,
  parameter int C_NUM_SUBIMAGES   = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_new_frame,
  input  logic [1:0] i_curr_frame_loc,
  input  logic [1:0] i_prev_frame_loc,
  input  logic       i_rd_ready,
  output logic       o_rd_valid,
  output logic [8:0] o_bram_array_read_addr,
  output logic [3:0] o_bram_select,
  output logic       o_tag_valid,
  output logic [3:0] o_tag_subimage,
  output logic       o_tag_is_prev,
  output logic [5:0] o_tag_line,
  output logic       o_tag_last,
  output logic       o_busy,
  output logic       o_frame_done,
  output logic       o_overrun
);

  localparam logic [5:0] LINE_LAST = 6'(C_SUBIMAGE_HEIGHT - 1);
  localparam logic [3:0] SUB_LAST  = 4'(C_NUM_SUBIMAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CURR = 2'd1,
    S_PREV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [3:0] sub_r, sub_s;
  logic [5:0] line_r, line_s;
  logic [1:0] curr_loc_r, curr_loc_s;
  logic [1:0] prev_loc_r, prev_loc_s;
  logic       accept_s, last_beat_s, overrun_s, reading_s;
  logic [1:0] rd_loc_s;

  logic       rd_valid_r;
  logic [8:0] addr_r;
  logic [3:0] select_r;
  logic       tag_valid_r, tag_is_prev_r, tag_last_r;
  logic [3:0] tag_sub_r;
  logic [5:0] tag_line_r;
  logic       busy_r, frame_done_r, overrun_r;

  // Beat handshake and final-beat detection on the current state.
  always_comb begin
    accept_s    = ((state_r == S_CURR) || (state_r == S_PREV)) && i_rd_ready;
    last_beat_s = accept_s && (state_r == S_PREV) && (sub_r == SUB_LAST) && (line_r == LINE_LAST);
  end

  // Next-state, counter and location update; a new frame always wins over the walk.
  always_comb begin
    state_s    = state_r;
    sub_s      = sub_r;
    line_s     = line_r;
    curr_loc_s = curr_loc_r;
    prev_loc_s = prev_loc_r;
    overrun_s  = 1'b0;
    if (i_new_frame) begin
      state_s    = S_CURR;
      sub_s      = 4'd0;
      line_s     = 6'd0;
      curr_loc_s = i_curr_frame_loc;
      prev_loc_s = i_prev_frame_loc;
      overrun_s  = (state_r != S_IDLE);
    end else begin
      case (state_r)
        S_IDLE: state_s = S_IDLE;
        S_CURR: begin
          if (accept_s) begin
            if (line_r == LINE_LAST) begin
              line_s  = 6'd0;
              state_s = S_PREV;
            end else begin
              line_s = line_r + 6'd1;
            end
          end else begin
            state_s = S_CURR;
          end
        end
        S_PREV: begin
          if (accept_s) begin
            if (line_r == LINE_LAST) begin
              line_s = 6'd0;
              if (sub_r == SUB_LAST) begin
                sub_s   = 4'd0;
                state_s = S_DONE;
              end else begin
                sub_s   = sub_r + 4'd1;
                state_s = S_CURR;
              end
            end else begin
              line_s = line_r + 6'd1;
            end
          end else begin
            state_s = S_PREV;
          end
        end
        S_DONE:  state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Request decode for the state being entered, so the request outputs can be registered.
  always_comb begin
    reading_s = (state_s == S_CURR) || (state_s == S_PREV);
    if (state_s == S_PREV) begin
      rd_loc_s = prev_loc_s;
    end else begin
      rd_loc_s = curr_loc_s;
    end
  end

  // State, counters, registered request/status outputs and the one-cycle tag pipeline.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r       <= S_IDLE;
      sub_r         <= 4'd0;
      line_r        <= 6'd0;
      curr_loc_r    <= 2'd0;
      prev_loc_r    <= 2'd0;
      rd_valid_r    <= 1'b0;
      addr_r        <= 9'd0;
      select_r      <= 4'd0;
      tag_valid_r   <= 1'b0;
      tag_sub_r     <= 4'd0;
      tag_is_prev_r <= 1'b0;
      tag_line_r    <= 6'd0;
      tag_last_r    <= 1'b0;
      busy_r        <= 1'b0;
      frame_done_r  <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      sub_r         <= sub_s;
      line_r        <= line_s;
      curr_loc_r    <= curr_loc_s;
      prev_loc_r    <= prev_loc_s;
      rd_valid_r    <= reading_s;
      addr_r        <= reading_s ? {1'b0, rd_loc_s, line_s} : 9'd0;
      select_r      <= reading_s ? sub_s : 4'd0;
      tag_valid_r   <= accept_s;
      tag_sub_r     <= accept_s ? sub_r : 4'd0;
      tag_is_prev_r <= accept_s && (state_r == S_PREV);
      tag_line_r    <= accept_s ? line_r : 6'd0;
      tag_last_r    <= last_beat_s;
      busy_r        <= (state_s != S_IDLE);
      frame_done_r  <= (state_s == S_DONE);
      overrun_r     <= overrun_s;
    end
  end

  assign o_rd_valid             = rd_valid_r;
  assign o_bram_array_read_addr = addr_r;
  assign o_bram_select          = select_r;
  assign o_tag_valid            = tag_valid_r;
  assign o_tag_subimage         = tag_sub_r;
  assign o_tag_is_prev          = tag_is_prev_r;
  assign o_tag_line             = tag_line_r;
  assign o_tag_last             = tag_last_r;
  assign o_busy                 = busy_r;
  assign o_frame_done           = frame_done_r;
  assign o_overrun              = overrun_r;

endmodule

// File: tb/tb_gcbp_read_sched.sv
// Scoreboard bench for gcbp_read_sched: expected beats are queued per frame, a monitor
// pops them on every accepted request and again when the matching tag returns.
module tb_gcbp_read_sched;

  logic       i_clk = 1'b0;
  logic       i_reset, i_new_frame, i_rd_ready;
  logic [1:0] i_curr_frame_loc, i_prev_frame_loc;
  logic       o_rd_valid, o_tag_valid, o_tag_is_prev, o_tag_last, o_busy, o_frame_done, o_overrun;
  logic [8:0] o_bram_array_read_addr;
  logic [3:0] o_bram_select, o_tag_subimage;
  logic [5:0] o_tag_line;

  typedef struct packed {
    logic [8:0] addr;
    logic [3:0] sub;
    logic       prev;
    logic [5:0] line;
    logic       last;
  } beat_t;

  beat_t req_q[$];
  beat_t tag_q[$];
  int    checks = 0, errors = 0;
  int    acc_cnt = 0, done_cnt = 0, over_cnt = 0, last_cnt = 0;
  bit    rand_ready = 1'b0;

  gcbp_read_sched dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_new_frame(i_new_frame),
    .i_curr_frame_loc(i_curr_frame_loc), .i_prev_frame_loc(i_prev_frame_loc),
    .i_rd_ready(i_rd_ready), .o_rd_valid(o_rd_valid),
    .o_bram_array_read_addr(o_bram_array_read_addr), .o_bram_select(o_bram_select),
    .o_tag_valid(o_tag_valid), .o_tag_subimage(o_tag_subimage), .o_tag_is_prev(o_tag_is_prev),
    .o_tag_line(o_tag_line), .o_tag_last(o_tag_last), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [1:0] c, input logic [1:0] p);
    beat_t b;
    for (int s = 0; s < 16; s++)
      for (int ph = 0; ph < 2; ph++)
        for (int l = 0; l < 64; l++) begin
          b.sub  = 4'(s);
          b.prev = (ph == 1);
          b.line = 6'(l);
          b.addr = {1'b0, ((ph == 1) ? p : c), 6'(l)};
          b.last = (s == 15) && (ph == 1) && (l == 63);
          req_q.push_back(b);
        end
  endtask

  // Called at posedge+1; pulses i_new_frame for one cycle and replaces the expected requests.
  task automatic start_frame(input logic [1:0] c, input logic [1:0] p);
    i_curr_frame_loc = c;
    i_prev_frame_loc = p;
    i_new_frame      = 1'b1;
    @(posedge i_clk); #1;
    i_new_frame = 1'b0;
    req_q.delete();
    push_frame(c, p);
  endtask

  task automatic wait_acc(input int target, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge i_clk); #1;
      if (acc_cnt >= target) ok = 1'b1;
    end
    chk({"reach_", name}, 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge i_clk); #1;
      if (!o_busy && req_q.size() == 0 && tag_q.size() == 0) ok = 1'b1;
    end
    chk({"idle_", name}, 32'(ok), 32'd1);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {2'b00, o_rd_valid, o_bram_array_read_addr, o_bram_select, o_tag_valid,
               o_tag_subimage, o_tag_is_prev, o_tag_line, o_tag_last, o_busy,
               o_frame_done, o_overrun}, 32'd0);
  endtask

  // Ready driver: held high, or a coin flip each cycle.
  initial begin
    i_rd_ready = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      i_rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  beat_t      mon_e;
  logic       mon_acc, prev_stall = 1'b0, prev_ctl = 1'b0;
  logic [8:0] prev_addr = 9'd0;
  logic [3:0] prev_sel = 4'd0;

  // Monitor: returning tags first (owed by last cycle's accept), then this cycle's accept.
  always @(negedge i_clk) begin
    chk("tag_valid", 32'(o_tag_valid), 32'(tag_q.size() != 0));
    if (o_tag_valid && tag_q.size() != 0) begin
      mon_e = tag_q.pop_front();
      chk("tag_subimage", 32'(o_tag_subimage), 32'(mon_e.sub));
      chk("tag_is_prev", 32'(o_tag_is_prev), 32'(mon_e.prev));
      chk("tag_line", 32'(o_tag_line), 32'(mon_e.line));
      chk("tag_last", 32'(o_tag_last), 32'(mon_e.last));
    end
    mon_acc = o_rd_valid && i_rd_ready && !i_reset;
    if (mon_acc) begin
      acc_cnt++;
      if (req_q.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = req_q.pop_front();
        chk("rd_addr", 32'(o_bram_array_read_addr), 32'(mon_e.addr));
        chk("rd_select", 32'(o_bram_select), 32'(mon_e.sub));
        tag_q.push_back(mon_e);
      end
    end
    if (prev_stall && !prev_ctl) begin
      chk("stall_valid", 32'(o_rd_valid), 32'd1);
      chk("stall_addr", 32'(o_bram_array_read_addr), 32'(prev_addr));
      chk("stall_select", 32'(o_bram_select), 32'(prev_sel));
    end
    prev_stall = o_rd_valid && !i_rd_ready;
    prev_ctl   = i_new_frame || i_reset;
    prev_addr  = o_bram_array_read_addr;
    prev_sel   = o_bram_select;
    if (o_frame_done) begin
      done_cnt++;
      chk("done_busy", 32'(o_busy), 32'd1);
      chk("done_with_last", 32'(o_tag_last), 32'd1);
    end
    if (o_overrun) over_cnt++;
    if (o_tag_last) last_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    int  base;
    i_reset = 1'b1; i_new_frame = 1'b0;
    i_curr_frame_loc = 2'd0; i_prev_frame_loc = 2'd0;
    repeat (3) @(posedge i_clk);
    #1;
    i_new_frame = 1'b1;
    i_curr_frame_loc = 2'd1;
    @(negedge i_clk);
    chk_zero("reset_outputs");
    @(posedge i_clk); #1;
    i_new_frame = 1'b0;
    i_reset     = 1'b0;
    @(negedge i_clk);
    chk("new_frame_in_reset_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;

    // Full frame, ready held high: latency to o_frame_done and busy drop.
    rand_ready = 1'b0;
    start_frame(2'd1, 2'd2);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge i_clk);
      n++;
      if (o_frame_done) seen = 1'b1;
    end
    chk("done_latency", 32'(n), 32'd2049);
    @(negedge i_clk);
    chk("busy_after_done", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    chk("frame1_done_cnt", 32'(done_cnt), 32'd1);
    chk("frame1_last_cnt", 32'(last_cnt), 32'd1);
    chk("frame1_overrun_cnt", 32'(over_cnt), 32'd0);

    // Random ready, curr=3 prev=0.
    rand_ready = 1'b1;
    start_frame(2'd3, 2'd0);
    wait_idle(6000, "frame2");
    chk("frame2_done_cnt", 32'(done_cnt), 32'd2);
    chk("frame2_last_cnt", 32'(last_cnt), 32'd2);

    // Abort at beat 700.
    rand_ready = 1'b0;
    start_frame(2'd2, 2'd1);
    base = acc_cnt;
    wait_acc(base + 700, 1000, "beat700");
    start_frame(2'd3, 2'd0);
    @(negedge i_clk);
    chk("abort_overrun", 32'(o_overrun), 32'd1);
    chk("abort_valid", 32'(o_rd_valid), 32'd1);
    chk("abort_addr", 32'(o_bram_array_read_addr), 32'h0C0);
    chk("abort_select", 32'(o_bram_select), 32'd0);
    chk("abort_done", 32'(o_frame_done), 32'd0);
    wait_idle(3000, "abort");
    chk("abort_done_cnt", 32'(done_cnt), 32'd3);
    chk("abort_overrun_cnt", 32'(over_cnt), 32'd1);

    // Reset while reading sub-image 9 previous-frame lines.
    rand_ready = 1'b1;
    start_frame(2'd1, 2'd3);
    base = acc_cnt;
    wait_acc(base + 9 * 128 + 64 + 10, 6000, "sub9_prev");
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_new_frame = 1'b1;
    req_q.delete();
    @(negedge i_clk);
    chk_zero("mid_reset_outputs");
    @(posedge i_clk); #1;
    i_new_frame = 1'b0;
    i_reset     = 1'b0;
    @(negedge i_clk);
    chk("reset_ignores_new_frame", 32'({o_busy, o_rd_valid}), 32'd0);
    @(posedge i_clk); #1;
    start_frame(2'd0, 2'd1);
    wait_idle(6000, "after_reset");
    chk("reset_done_cnt", 32'(done_cnt), 32'd4);
    chk("reset_overrun_cnt", 32'(over_cnt), 32'd1);

    // New frame coinciding with the final accept.
    rand_ready = 1'b0;
    @(posedge i_clk); #1;
    start_frame(2'd1, 2'd2);
    base = acc_cnt;
    wait_acc(base + 2047, 3000, "final_beat");
    start_frame(2'd2, 2'd3);
    @(negedge i_clk);
    chk("coinc_overrun", 32'(o_overrun), 32'd1);
    chk("coinc_no_done", 32'(o_frame_done), 32'd0);
    chk("coinc_addr", 32'(o_bram_array_read_addr), 32'h080);
    chk("coinc_select", 32'(o_bram_select), 32'd0);
    wait_idle(3000, "coinc");
    chk("coinc_done_cnt", 32'(done_cnt), 32'd5);
    chk("coinc_overrun_cnt", 32'(over_cnt), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
